microbot_motion_sequencer: RTL and testbench
============================================

Name: microbot_motion_sequencer

Overview:
Sequences the microbot drive outputs from debounced obstacle sensors and from host motion commands. Obstacle avoidance has priority over the host. Timed reverse and turn manoeuvres run for fixed cycle counts. The block sits between the sensor pins and the two motor driver pairs. It also exposes its state for debug output pins.

Parameters:
DEB_CYCLES, 3, consecutive equal samples required before a filtered sensor bit changes (1..15)
REV_CYCLES, 8, cycles spent in REV per manoeuvre (1..255)
TURN_CYCLES, 16, cycles spent in TURN_L/TURN_R per manoeuvre (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  run enable; low freezes the FSM
sensor  in  3  raw obstacle sensors: [2]=left, [1]=centre, [0]=right
cmd_valid  in  1  host command valid
cmd  in  2  00 STOP, 01 GO, 10 SPIN_L, 11 SPIN_R
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
motor_l  out  2  left motor drive: 10 forward, 01 reverse, 00 off
motor_r  out  2  right motor drive, same encoding as motor_l
state  out  3  0 IDLE, 1 FWD, 2 REV, 3 TURN_L, 4 TURN_R
busy  out  1  high in REV, TURN_L and TURN_R

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; motor_l=motor_r=00; busy=0; cmd_ready=0.
  - run flag=0; filtered sensors=000; debounce counters and manoeuvre timer=0.
  - Reset mid-manoeuvre aborts it at the same edge.
- Debounce (per bit, independent of en):
  - The counter increments while raw != filtered and clears when raw == filtered.
  - The filtered bit takes the raw value at the edge where the counter would reach DEB_CYCLES.
  - A glitch shorter than DEB_CYCLES cycles never reaches the FSM.
- Registered outputs: motors, busy and state are registered. They are a pure function of the next state, updated on the same edge as the state:
  - IDLE: motor_l=00, motor_r=00
  - FWD: motor_l=10, motor_r=10
  - REV: motor_l=01, motor_r=01
  - TURN_L: motor_l=01, motor_r=10
  - TURN_R: motor_l=10, motor_r=01
- cmd_ready (combinational) = en && !rst && (state==IDLE || (state==FWD && filt==000)).
- en low: state, timer and run flag hold; cmd_ready=0; motor outputs read 00. Normal outputs resume on the first edge after en returns high.
- IDLE transitions (sensors ignored):
  - GO: run=1, go to FWD.
  - SPIN_L: go to TURN_L.
  - SPIN_R: go to TURN_R.
  - STOP: no effect.
- FWD, obstacle present (evaluated first; blocks command acceptance):
  - filt[1]=1, or filt==101: go to REV, then TURN_R.
  - filt==100: go to TURN_R.
  - filt==001: go to TURN_L.
- FWD, filt==000, commands:
  - STOP: run=0, go to IDLE.
  - GO: no change.
  - SPIN_L / SPIN_R: go to TURN_L / TURN_R.
- Manoeuvre timer:
  - Loaded with REV_CYCLES-1 or TURN_CYCLES-1 on entry.
  - Decrements each enabled cycle; the manoeuvre exits on the edge where it is 0.
  - A state is therefore held exactly N enabled cycles.
- Manoeuvre exits:
  - REV exits to TURN_R.
  - TURN_x exits to FWD if run=1, else IDLE.
  - Manoeuvres are not interruptible by sensors or commands.
- Latency: a sensor stable from edge k gives filtered change at edge k+DEB_CYCLES-1 and motor change at the next edge.

Optional Feature:
AVOID_CNT_EN:
- Defined:
  - Adds output avoid_cnt[7:0].
  - Increments by 1 on each FWD-to-REV/TURN transition caused by sensors; host spins are not counted.
  - Saturates at 255; reset to 0 by rst.
- Undefined: no port and no counter logic.

Test Plan:
- Reset/idle: assert rst 2 cycles with sensor=111 -> state=0, motors 00/00, cmd_ready=1 after release, filtered stays 000 for the first 2 post-reset cycles.
- GO then centre obstacle: cmd=01 accepted -> FWD (10/10). Set sensor=010 -> exactly 8 cycles REV (01/01), then 16 cycles TURN_R (10/01), then FWD; cmd_ready=0 throughout busy.
- Side obstacles and glitch: in FWD, sensor=100 -> TURN_R 16 cycles; sensor=001 -> TURN_L; a 2-cycle pulse of 010 -> no state change.
- Command priority: in FWD, assert cmd_valid=1, cmd=00 in the same cycle the filtered centre sensor goes high -> command not accepted, REV entered, run still 1, return to FWD.
- SPIN from IDLE with run=0: cmd=10 -> TURN_L 16 cycles, then IDLE. en low mid-turn for 5 cycles -> motors 00, timer holds, turn completes 5 cycles late.
- AVOID_CNT_EN: 300 centre-obstacle manoeuvres -> avoid_cnt=255; 2 spins add nothing.

Source files
------------

// File: rtl/microbot_motion_sequencer.sv
// Microbot motion sequencer: debounced obstacle avoidance with priority over host motion commands.
// Latency: a stable raw sensor reaches the filter after DEB_CYCLES-1 edges and the motors one edge later.
// Backpressure: cmd_ready is low while en is low, during manoeuvres, or while an obstacle is seen in FWD.
// Optional feature: define AVOID_CNT_EN to add the saturating avoid_cnt[7:0] output.
module microbot_motion_sequencer #(
  parameter int DEB_CYCLES  = 3,
  parameter int REV_CYCLES  = 8,
  parameter int TURN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] sensor,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic [2:0] state,
  output logic       busy
`ifdef AVOID_CNT_EN
  ,
  output logic [7:0] avoid_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_REV    = 3'd2,
    S_TURN_L = 3'd3,
    S_TURN_R = 3'd4
  } state_e;

  localparam logic [1:0] CMD_STOP   = 2'b00;
  localparam logic [1:0] CMD_GO     = 2'b01;
  localparam logic [1:0] CMD_SPIN_L = 2'b10;
  localparam logic [1:0] CMD_SPIN_R = 2'b11;

  localparam logic [1:0] DRV_OFF = 2'b00;
  localparam logic [1:0] DRV_FWD = 2'b10;
  localparam logic [1:0] DRV_REV = 2'b01;

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [7:0] REV_LOAD  = 8'(REV_CYCLES - 1);
  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic            run_q, run_d;
  logic [2:0]      filt_q, filt_d;
  logic [2:0][3:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]      motor_l_q, motor_l_d;
  logic [1:0]      motor_r_q, motor_r_d;
  logic            busy_q, busy_d;
  logic            cmd_acc;

  assign cmd_ready = en && !rst &&
                     ((state_q == S_IDLE) || ((state_q == S_FWD) && (filt_q == 3'b000)));
  assign cmd_acc   = cmd_valid && cmd_ready;

  // Per-bit debounce: the filtered bit flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sensor[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          filt_d[i]    = sensor[i];
          deb_cnt_d[i] = 4'd0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end else begin
        deb_cnt_d[i] = 4'd0;
      end
    end
  end

  // Next-state logic: sensors win in FWD, manoeuvres run to completion, en low freezes everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    run_d   = run_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (cmd_acc) begin
            case (cmd)
              CMD_GO: begin
                run_d   = 1'b1;
                state_d = S_FWD;
              end
              CMD_SPIN_L: begin
                state_d = S_TURN_L;
                timer_d = TURN_LOAD;
              end
              CMD_SPIN_R: begin
                state_d = S_TURN_R;
                timer_d = TURN_LOAD;
              end
              default: ;
            endcase
          end
        end
        S_FWD: begin
          if (filt_q[1] || (filt_q == 3'b101)) begin
            state_d = S_REV;
            timer_d = REV_LOAD;
          end else if (filt_q == 3'b100) begin
            state_d = S_TURN_R;
            timer_d = TURN_LOAD;
          end else if (filt_q == 3'b001) begin
            state_d = S_TURN_L;
            timer_d = TURN_LOAD;
          end else if (cmd_acc) begin
            case (cmd)
              CMD_STOP: begin
                run_d   = 1'b0;
                state_d = S_IDLE;
              end
              CMD_SPIN_L: begin
                state_d = S_TURN_L;
                timer_d = TURN_LOAD;
              end
              CMD_SPIN_R: begin
                state_d = S_TURN_R;
                timer_d = TURN_LOAD;
              end
              default: ;
            endcase
          end
        end
        S_REV: begin
          if (timer_q == 8'd0) begin
            state_d = S_TURN_R;
            timer_d = TURN_LOAD;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        S_TURN_L, S_TURN_R: begin
          if (timer_q == 8'd0) begin
            state_d = run_q ? S_FWD : S_IDLE;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state; motors are forced off while disabled.
  always_comb begin
    motor_l_d = DRV_OFF;
    motor_r_d = DRV_OFF;
    busy_d    = (state_d == S_REV) || (state_d == S_TURN_L) || (state_d == S_TURN_R);
    if (en) begin
      case (state_d)
        S_FWD:    begin motor_l_d = DRV_FWD; motor_r_d = DRV_FWD; end
        S_REV:    begin motor_l_d = DRV_REV; motor_r_d = DRV_REV; end
        S_TURN_L: begin motor_l_d = DRV_REV; motor_r_d = DRV_FWD; end
        S_TURN_R: begin motor_l_d = DRV_FWD; motor_r_d = DRV_REV; end
        default:  begin motor_l_d = DRV_OFF; motor_r_d = DRV_OFF; end
      endcase
    end
  end

  // State, timer, filter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= 8'd0;
      run_q     <= 1'b0;
      filt_q    <= 3'b000;
      deb_cnt_q <= '0;
      motor_l_q <= DRV_OFF;
      motor_r_q <= DRV_OFF;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      run_q     <= run_d;
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
      motor_l_q <= motor_l_d;
      motor_r_q <= motor_r_d;
      busy_q    <= busy_d;
    end
  end

  assign state   = state_q;
  assign motor_l = motor_l_q;
  assign motor_r = motor_r_q;
  assign busy    = busy_q;

`ifdef AVOID_CNT_EN
  logic [7:0] avoid_cnt_q;
  logic       avoid_hit;

  // Any obstacle seen while enabled in FWD forces a manoeuvre, so that is exactly one avoidance.
  assign avoid_hit = en && (state_q == S_FWD) && (filt_q != 3'b000);

  // Saturating count of sensor-triggered manoeuvres.
  always_ff @(posedge clk) begin
    if (rst) begin
      avoid_cnt_q <= 8'd0;
    end else if (avoid_hit && (avoid_cnt_q != 8'hFF)) begin
      avoid_cnt_q <= avoid_cnt_q + 8'd1;
    end
  end

  assign avoid_cnt = avoid_cnt_q;
`endif

endmodule

// File: tb/tb_microbot_motion_sequencer.sv
// Bench for microbot_motion_sequencer: per-cycle expected outputs are queued, then popped and compared.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: cmd_ready is part of every queued expectation.
module tb_microbot_motion_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FWD = 3'd1, ST_REV = 3'd2, ST_TL = 3'd3, ST_TR = 3'd4;

  logic       clk, rst, en, cmd_valid, cmd_ready, busy;
  logic [2:0] sensor, state;
  logic [1:0] cmd, motor_l, motor_r;
`ifdef AVOID_CNT_EN
  logic [7:0] avoid_cnt;
`endif

  microbot_motion_sequencer #(.DEB_CYCLES(3), .REV_CYCLES(8), .TURN_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sensor(sensor),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .motor_l(motor_l), .motor_r(motor_r), .state(state), .busy(busy)
`ifdef AVOID_CNT_EN
    , .avoid_cnt(avoid_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [1:0] ml;
    logic [1:0] mr;
    logic       bsy;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] ml, input logic [1:0] mr,
                      input logic bsy, input logic rdy, input int n);
    exp_t e;
    e.st = st; e.ml = ml; e.mr = mr; e.bsy = bsy; e.rdy = rdy;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Motor and busy values follow the state table of the block.
  task automatic push_st(input logic [2:0] st, input logic rdy, input int n);
    case (st)
      ST_FWD:  push(st, 2'b10, 2'b10, 1'b0, rdy, n);
      ST_REV:  push(st, 2'b01, 2'b01, 1'b1, rdy, n);
      ST_TL:   push(st, 2'b01, 2'b10, 1'b1, rdy, n);
      ST_TR:   push(st, 2'b10, 2'b01, 1'b1, rdy, n);
      default: push(st, 2'b00, 2'b00, 1'b0, rdy, n);
    endcase
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      chk({tag, ".state"}, 32'(state), 32'(e.st));
      chk({tag, ".motor_l"}, 32'(motor_l), 32'(e.ml));
      chk({tag, ".motor_r"}, 32'(motor_r), 32'(e.mr));
      chk({tag, ".busy"}, 32'(busy), 32'(e.bsy));
      chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(e.rdy));
    end
  endtask

  task automatic wait_for(input logic [2:0] st, input string tag);
    int n = 0;
    while (state !== st && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(state), 32'(st));
  endtask

  // Obstacle from FWD: 3 edges to filter, one to react, then the manoeuvre and back to FWD.
  task automatic avoid_seq(input logic [2:0] s, input logic rev, input string tag);
    logic [2:0] first;
    first = rev ? ST_REV : ((s == 3'b100) ? ST_TR : ST_TL);
    sensor = s;
    push_st(ST_FWD, 1'b1, 2);
    push_st(ST_FWD, 1'b0, 1);
    push_st(first, 1'b0, 1);
    drain({tag, ".entry"});
    sensor = 3'b000;
    if (rev) begin
      push_st(ST_REV, 1'b0, 7);
      push_st(ST_TR, 1'b0, 16);
    end else begin
      push_st(first, 1'b0, 15);
    end
    push_st(ST_FWD, 1'b1, 1);
    drain({tag, ".body"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; sensor = 3'b111; cmd_valid = 1'b0; cmd = 2'b00;
    tick(); tick();
    chk("rst.state", 32'(state), 32'(ST_IDLE));
    chk("rst.motor_l", 32'(motor_l), 32'd0);
    chk("rst.motor_r", 32'(motor_r), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    sensor = 3'b000;
    #1;
    chk("post_rst.cmd_ready", 32'(cmd_ready), 32'd1);
    push_st(ST_IDLE, 1'b1, 3);
    drain("idle");

    cmd_valid = 1'b1; cmd = 2'b01;
    push_st(ST_FWD, 1'b1, 1);
    drain("go");
    cmd_valid = 1'b0;

    avoid_seq(3'b010, 1'b1, "centre");
    avoid_seq(3'b100, 1'b0, "left_obst");
    avoid_seq(3'b001, 1'b0, "right_obst");

    // Two-cycle centre glitch must never reach the FSM.
    sensor = 3'b010;
    push_st(ST_FWD, 1'b1, 2);
    drain("glitch.on");
    sensor = 3'b000;
    push_st(ST_FWD, 1'b1, 3);
    drain("glitch.off");

    // STOP offered in the cycle the centre filter rises: rejected, REV taken, run stays set.
    sensor = 3'b010;
    push_st(ST_FWD, 1'b1, 2);
    push_st(ST_FWD, 1'b0, 1);
    drain("prio.pre");
    cmd_valid = 1'b1; cmd = 2'b00;
    #1;
    chk("prio.cmd_ready", 32'(cmd_ready), 32'd0);
    push_st(ST_REV, 1'b0, 1);
    drain("prio.entry");
    cmd_valid = 1'b0;
    sensor = 3'b000;
    push_st(ST_REV, 1'b0, 7);
    push_st(ST_TR, 1'b0, 16);
    push_st(ST_FWD, 1'b1, 1);
    drain("prio.body");

    cmd_valid = 1'b1; cmd = 2'b00;
    push_st(ST_IDLE, 1'b1, 1);
    drain("stop");
    cmd_valid = 1'b0;

    // Spin from IDLE with run clear, frozen for 5 cycles mid-turn.
    cmd_valid = 1'b1; cmd = 2'b10;
    push_st(ST_TL, 1'b0, 1);
    drain("spin.entry");
    cmd_valid = 1'b0;
    push_st(ST_TL, 1'b0, 5);
    drain("spin.pre");
    en = 1'b0;
    push(ST_TL, 2'b00, 2'b00, 1'b1, 1'b0, 5);
    drain("spin.frozen");
    en = 1'b1;
    push_st(ST_TL, 1'b0, 10);
    push_st(ST_IDLE, 1'b1, 1);
    drain("spin.resume");

`ifdef AVOID_CNT_EN
    chk("avoid.count4", 32'(avoid_cnt), 32'd4);
    cmd_valid = 1'b1; cmd = 2'b01;
    tick();
    cmd_valid = 1'b0;
    chk("avoid.go", 32'(state), 32'(ST_FWD));
    cmd_valid = 1'b1; cmd = 2'b10;
    tick();
    cmd_valid = 1'b0;
    wait_for(ST_FWD, "avoid.spin_l");
    cmd_valid = 1'b1; cmd = 2'b11;
    tick();
    cmd_valid = 1'b0;
    wait_for(ST_FWD, "avoid.spin_r");
    chk("avoid.spins_uncounted", 32'(avoid_cnt), 32'd4);
    for (int i = 0; i < 300; i++) begin
      sensor = 3'b010;
      wait_for(ST_REV, "avoid.loop_rev");
      sensor = 3'b000;
      wait_for(ST_FWD, "avoid.loop_fwd");
    end
    chk("avoid.saturated", 32'(avoid_cnt), 32'd255);
`endif

    // Reset in the middle of REV aborts the manoeuvre at that edge.
    cmd_valid = 1'b1; cmd = 2'b01;
    tick();
    cmd_valid = 1'b0;
    sensor = 3'b010;
    wait_for(ST_REV, "midrst.rev");
    tick(); tick(); tick();
    rst = 1'b1;
    sensor = 3'b000;
    tick();
    chk("midrst.state", 32'(state), 32'(ST_IDLE));
    chk("midrst.motor_l", 32'(motor_l), 32'd0);
    chk("midrst.motor_r", 32'(motor_r), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.cmd_ready", 32'(cmd_ready), 32'd0);
`ifdef AVOID_CNT_EN
    chk("midrst.avoid_cnt", 32'(avoid_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("midrst.release_ready", 32'(cmd_ready), 32'd1);
    push_st(ST_IDLE, 1'b1, 2);
    drain("midrst.idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
